// File: rtl/slink_diag_pkg.sv
// Shared types and constants for the multi-channel serial-link diagnostics block.
// Holds the per-channel FSM state encoding and the cause-vector bit layout.
package slink_diag_pkg;

  localparam int CAUSE_W   = 5;
  localparam int CAUSE_BRK = 4;
  localparam int CAUSE_LEN = 3;
  localparam int CAUSE_TCK = 2;
  localparam int CAUSE_CRC = 1;
  localparam int CAUSE_DLY = 0;

  typedef logic [CAUSE_W-1:0] cause_t;

  // A channel out of reset is reported as broken until its link comes up.
  localparam cause_t CAUSE_RST = 5'b10000;

  typedef enum logic [1:0] {
    ST_OFFLINE = 2'd0,
    ST_HOLD    = 2'd1,
    ST_ONLINE  = 2'd2,
    ST_FAULT   = 2'd3
  } chn_state_e;

endpackage

// File: rtl/slink_diag_chn.sv
// One diagnosed link channel: link-state FSM, leaky saturating error counters
// and the registered live-cause vector. Unaffected by SLINK_DIAG_STICKY_EN.
module slink_diag_chn
  import slink_diag_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LEN_THR    = 10,
  parameter int unsigned TICK_THR   = 10,
  parameter int unsigned CRC_THR    = 10,
  parameter int unsigned DLY_THR    = 100,
  parameter int unsigned DECAY_PKTS = 16,
  parameter int unsigned HOLD_CYC   = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   break_err,
  input  logic   len_err,
  input  logic   tick_err,
  input  logic   crc_err,
  input  logic   delay_err,
  input  logic   eop,
  output cause_t cause
);

  localparam int unsigned GOOD_W = (DECAY_PKTS > 0) ? $clog2(DECAY_PKTS + 1) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  chn_state_e        state_q, state_d;
  logic              brk_prev_q, dly_q;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  cnt_t              len_cnt_q, len_cnt_d;
  cnt_t              tick_cnt_q, tick_cnt_d;
  cnt_t              crc_cnt_q, crc_cnt_d;
  cnt_t              dly_cnt_q, dly_cnt_d;
  cause_t            cause_q, cause_d;

  logic brk_fall, dly_fall, active, pkt_good, decay;
  logic len_hit, tick_hit, crc_hit, dly_hit, fault_cond;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic cnt_t sat_dec(input cnt_t v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
  always_comb begin
    brk_fall   = brk_prev_q & ~break_err;
    dly_fall   = dly_q & ~delay_err;
    active     = (state_q == ST_ONLINE) || (state_q == ST_FAULT);
    pkt_good   = eop & ~len_err & ~tick_err & ~crc_err;

    len_hit    = 32'(len_cnt_q)  >= LEN_THR;
    tick_hit   = 32'(tick_cnt_q) >= TICK_THR;
    crc_hit    = 32'(crc_cnt_q)  >= CRC_THR;
    dly_hit    = 32'(dly_cnt_q)  >= DLY_THR;
    fault_cond = len_hit | tick_hit | crc_hit | dly_hit | dly_q;

    state_d    = state_q;
    hold_cnt_d = (state_q == ST_HOLD) ? hold_cnt_q + HOLD_W'(1) : '0;
    unique case (state_q)
      ST_OFFLINE: if (brk_fall) state_d = ST_HOLD;
      ST_HOLD:    if (32'(hold_cnt_q) + 32'd1 >= HOLD_CYC) state_d = ST_ONLINE;
      ST_ONLINE:  if (fault_cond) state_d = ST_FAULT;
      ST_FAULT:   if (!fault_cond) state_d = ST_ONLINE;
      default:    state_d = ST_OFFLINE;
    endcase
    if (break_err) state_d = ST_OFFLINE;

    // Any errored packet restarts the run of consecutive good packets.
    decay      = 1'b0;
    good_cnt_d = good_cnt_q;
    if (DECAY_PKTS != 0 && active && eop) begin
      if (!pkt_good) begin
        good_cnt_d = '0;
      end else if (32'(good_cnt_q) + 32'd1 >= DECAY_PKTS) begin
        decay      = 1'b1;
        good_cnt_d = '0;
      end else begin
        good_cnt_d = good_cnt_q + GOOD_W'(1);
      end
    end

    len_cnt_d  = len_cnt_q;
    tick_cnt_d = tick_cnt_q;
    crc_cnt_d  = crc_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    if (brk_fall) begin
      len_cnt_d  = '0;
      tick_cnt_d = '0;
      crc_cnt_d  = '0;
      dly_cnt_d  = '0;
      good_cnt_d = '0;
    end else if (active) begin
      if (eop && len_err)       len_cnt_d  = sat_inc(len_cnt_q);
      else if (decay)           len_cnt_d  = sat_dec(len_cnt_q);
      if (eop && tick_err)      tick_cnt_d = sat_inc(tick_cnt_q);
      else if (decay)           tick_cnt_d = sat_dec(tick_cnt_q);
      if (eop && crc_err)       crc_cnt_d  = sat_inc(crc_cnt_q);
      else if (decay)           crc_cnt_d  = sat_dec(crc_cnt_q);
      // A delay edge and a decay in the same cycle cancel out.
      if (dly_fall && !decay)   dly_cnt_d  = sat_inc(dly_cnt_q);
      else if (!dly_fall && decay) dly_cnt_d = sat_dec(dly_cnt_q);
    end

    // Break follows the next state so the OFFLINE->HOLD edge shows no gap.
    cause_d            = '0;
    cause_d[CAUSE_BRK] = break_err | (state_d == ST_HOLD);
    cause_d[CAUSE_LEN] = len_hit;
    cause_d[CAUSE_TCK] = tick_hit;
    cause_d[CAUSE_CRC] = crc_hit;
    cause_d[CAUSE_DLY] = dly_hit | dly_q;
  end

  // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFFLINE;
      brk_prev_q <= 1'b1;
      dly_q      <= 1'b0;
      hold_cnt_q <= '0;
      good_cnt_q <= '0;
      len_cnt_q  <= '0;
      tick_cnt_q <= '0;
      crc_cnt_q  <= '0;
      dly_cnt_q  <= '0;
      cause_q    <= CAUSE_RST;
    end else begin
      state_q    <= state_d;
      brk_prev_q <= break_err;
      dly_q      <= delay_err;
      hold_cnt_q <= hold_cnt_d;
      good_cnt_q <= good_cnt_d;
      len_cnt_q  <= len_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      crc_cnt_q  <= crc_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      cause_q    <= cause_d;
    end
  end

  assign cause = cause_q;

endmodule

// File: rtl/slink_diag_multi.sv
// Multi-channel serial-link diagnostics: CHN_NUM channel monitors plus a two-stage
// output pipeline. Define SLINK_DIAG_STICKY_EN to build the sticky cause registers.
module slink_diag_multi
  import slink_diag_pkg::*;
#(
  parameter int unsigned CHN_NUM    = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LEN_THR    = 10,
  parameter int unsigned TICK_THR   = 10,
  parameter int unsigned CRC_THR    = 10,
  parameter int unsigned DLY_THR    = 100,
  parameter int unsigned DECAY_PKTS = 16,
  parameter int unsigned HOLD_CYC   = 8
) (
  input  logic                         clk_125m,
  input  logic                         rst_125m,
  input  logic [CHN_NUM-1:0]           chn_break_err,
  input  logic [CHN_NUM-1:0]           chn_pkt_len_err,
  input  logic [CHN_NUM-1:0]           chn_pkt_tick_err,
  input  logic [CHN_NUM-1:0]           chn_pkt_crc_err,
  input  logic [CHN_NUM-1:0]           chn_pkt_delay_err,
  input  logic [CHN_NUM-1:0]           chn_pkt_eop,
  input  logic                         diag_clr,
  output logic [CHN_NUM-1:0]           slink_err,
  output logic [CAUSE_W*CHN_NUM-1:0]   slink_err_cause,
  output logic [CAUSE_W*CHN_NUM-1:0]   slink_err_sticky
);

  logic [CHN_NUM-1:0][CAUSE_W-1:0] cause_live;
  logic [CHN_NUM-1:0][CAUSE_W-1:0] cause_p1_q, cause_p2_q;
  logic [CHN_NUM-1:0]              err_d, err_p1_q, err_p2_q;

  for (genvar i = 0; i < CHN_NUM; i++) begin : g_chn
    slink_diag_chn #(
      .CNT_W      (CNT_W),
      .LEN_THR    (LEN_THR),
      .TICK_THR   (TICK_THR),
      .CRC_THR    (CRC_THR),
      .DLY_THR    (DLY_THR),
      .DECAY_PKTS (DECAY_PKTS),
      .HOLD_CYC   (HOLD_CYC)
    ) u_chn (
      .clk       (clk_125m),
      .rst_n     (rst_125m),
      .break_err (chn_break_err[i]),
      .len_err   (chn_pkt_len_err[i]),
      .tick_err  (chn_pkt_tick_err[i]),
      .crc_err   (chn_pkt_crc_err[i]),
      .delay_err (chn_pkt_delay_err[i]),
      .eop       (chn_pkt_eop[i]),
      .cause     (cause_live[i])
    );
  end

  always_comb begin
    err_d = '0;
    for (int i = 0; i < CHN_NUM; i++) err_d[i] = |cause_live[i];
  end

  always_ff @(posedge clk_125m or negedge rst_125m) begin
    if (!rst_125m) begin
      cause_p1_q <= {CHN_NUM{CAUSE_RST}};
      cause_p2_q <= {CHN_NUM{CAUSE_RST}};
      err_p1_q   <= '1;
      err_p2_q   <= '1;
    end else begin
      cause_p1_q <= cause_live;
      cause_p2_q <= cause_p1_q;
      err_p1_q   <= err_d;
      err_p2_q   <= err_p1_q;
    end
  end

  assign slink_err       = err_p2_q;
  assign slink_err_cause = cause_p2_q;

`ifdef SLINK_DIAG_STICKY_EN
  logic [CAUSE_W*CHN_NUM-1:0] sticky_q, sticky_d;

  // A live cause re-arms its bit even while a clear is requested.
  always_comb sticky_d = cause_live | (sticky_q & {CAUSE_W*CHN_NUM{~diag_clr}});

  always_ff @(posedge clk_125m or negedge rst_125m) begin
    if (!rst_125m) sticky_q <= '0;
    else           sticky_q <= sticky_d;
  end

  assign slink_err_sticky = sticky_q;
`else
  logic unused_diag_clr;
  assign unused_diag_clr  = diag_clr;
  assign slink_err_sticky = '0;
`endif

endmodule

// File: tb/tb_slink_diag_multi.sv
// Directed bench for slink_diag_multi: link bring-up, threshold faults, decay,
// saturation, break clearing, sticky clear/set priority and async reset.
module tb_slink_diag_multi;
  import slink_diag_pkg::*;

`ifdef SLINK_DIAG_STICKY_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  logic        clk_125m = 1'b0;
  logic        rst_125m;
  logic [3:0]  chn_break_err, chn_pkt_len_err, chn_pkt_tick_err;
  logic [3:0]  chn_pkt_crc_err, chn_pkt_delay_err, chn_pkt_eop;
  logic        diag_clr;
  logic [3:0]  slink_err;
  logic [19:0] slink_err_cause, slink_err_sticky;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] c;

  always #4 clk_125m = ~clk_125m;

  slink_diag_multi dut (
    .clk_125m          (clk_125m),
    .rst_125m          (rst_125m),
    .chn_break_err     (chn_break_err),
    .chn_pkt_len_err   (chn_pkt_len_err),
    .chn_pkt_tick_err  (chn_pkt_tick_err),
    .chn_pkt_crc_err   (chn_pkt_crc_err),
    .chn_pkt_delay_err (chn_pkt_delay_err),
    .chn_pkt_eop       (chn_pkt_eop),
    .diag_clr          (diag_clr),
    .slink_err         (slink_err),
    .slink_err_cause   (slink_err_cause),
    .slink_err_sticky  (slink_err_sticky)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_125m);
    #1;
  endtask

  function automatic logic [4:0] cause_of(input int ch);
    return slink_err_cause[ch*5 +: 5];
  endfunction

  function automatic logic [4:0] sticky_of(input int ch);
    return slink_err_sticky[ch*5 +: 5];
  endfunction

  initial begin
    rst_125m          = 1'b0;
    chn_break_err     = 4'hF;
    chn_pkt_len_err   = '0;
    chn_pkt_tick_err  = '0;
    chn_pkt_crc_err   = '0;
    chn_pkt_delay_err = '0;
    chn_pkt_eop       = '0;
    diag_clr          = 1'b0;
    #20;
    check("rst_err",    32'(slink_err),        32'hF);
    check("rst_cause",  32'(slink_err_cause),  32'h84210);
    check("rst_sticky", 32'(slink_err_sticky), 32'h0);
    @(negedge clk_125m) rst_125m = 1'b1;
    repeat (18) tick();

    // Link comes up on all channels: 8 cycles of HOLD, output lags by 2 stages.
    chn_break_err = '0;
    tick();
    check("hold_err_e0", 32'(slink_err[0]), 32'd1);
    repeat (9) tick();
    check("hold_err_e9", 32'(slink_err[0]), 32'd1);
    tick();
    check("hold_err_e10", 32'(slink_err[0]), 32'd0);
    check("all_online",   32'(slink_err),    32'h0);

    // Ten CRC-errored packets on channel 1.
    chn_pkt_eop[1] = 1'b1; chn_pkt_crc_err[1] = 1'b1;
    repeat (10) tick();
    chn_pkt_eop[1] = 1'b0; chn_pkt_crc_err[1] = 1'b0;
    check("crc_cnt10", 32'(dut.g_chn[1].u_chn.crc_cnt_q), 32'd10);
    repeat (2) tick();
    c = cause_of(1);
    check("crc_cause_n2", 32'(c[CAUSE_CRC]), 32'd0);
    tick();
    c = cause_of(1);
    check("crc_cause_n3", 32'(c[CAUSE_CRC]), 32'd1);
    check("crc_err_n3",   32'(slink_err[1]), 32'd1);
    check("ch1_fault",    32'(dut.g_chn[1].u_chn.state_q), 32'(ST_FAULT));
    check("ch0_quiet",    32'(slink_err[0]), 32'd0);

    // Sixteen good packets decay the CRC count by one.
    chn_pkt_eop[1] = 1'b1;
    repeat (15) tick();
    check("crc_cnt_pre_decay", 32'(dut.g_chn[1].u_chn.crc_cnt_q), 32'd10);
    tick();
    chn_pkt_eop[1] = 1'b0;
    check("crc_cnt9", 32'(dut.g_chn[1].u_chn.crc_cnt_q), 32'd9);
    repeat (2) tick();
    check("decay_err_m2", 32'(slink_err[1]), 32'd1);
    tick();
    check("decay_err_m3", 32'(slink_err[1]), 32'd0);
    check("ch1_online",   32'(dut.g_chn[1].u_chn.state_q), 32'(ST_ONLINE));

    // Length errors: 200 on channel 2, 300 on channel 3 (saturates at 255).
    chn_pkt_eop[3:2] = 2'b11; chn_pkt_len_err[3:2] = 2'b11;
    repeat (200) tick();
    chn_pkt_eop[2] = 1'b0; chn_pkt_len_err[2] = 1'b0;
    check("len_cnt200", 32'(dut.g_chn[2].u_chn.len_cnt_q), 32'd200);
    repeat (100) tick();
    chn_pkt_eop[3] = 1'b0; chn_pkt_len_err[3] = 1'b0;
    check("len_sat255", 32'(dut.g_chn[3].u_chn.len_cnt_q), 32'd255);
    repeat (3) tick();
    c = cause_of(3);
    check("ch3_len_cause", 32'(c[CAUSE_LEN]), 32'd1);
    check("ch3_err",       32'(slink_err[3]), 32'd1);

    // Break pulse on channel 2 wipes its counters.
    chn_break_err[2] = 1'b1;
    tick();
    chn_break_err[2] = 1'b0;
    tick();
    check("ch2_cleared", 32'(dut.g_chn[2].u_chn.len_cnt_q), 32'd0);
    check("ch2_hold",    32'(dut.g_chn[2].u_chn.state_q), 32'(ST_HOLD));
    repeat (12) tick();
    check("ch2_err_off",   32'(slink_err[2]), 32'd0);
    check("ch2_cause_off", 32'(cause_of(2)),  32'd0);
    check("ch2_online",    32'(dut.g_chn[2].u_chn.state_q), 32'(ST_ONLINE));

    // Delay error on channel 0, then clear, then clear colliding with a new error.
    chn_pkt_delay_err[0] = 1'b1;
    repeat (3) tick();
    chn_pkt_delay_err[0] = 1'b0;
    repeat (3) tick();
    c = sticky_of(0);
    check("stk_dly_set", 32'(c[CAUSE_DLY]), 32'(STICKY_ON));
    check("dly_cnt1",    32'(dut.g_chn[0].u_chn.dly_cnt_q), 32'd1);
    repeat (4) tick();
    diag_clr = 1'b1;
    tick();
    diag_clr = 1'b0;
    check("stk_ch0_clr", 32'(sticky_of(0)), 32'd0);
    check("stk_ch3_len", 32'(sticky_of(3)), STICKY_ON ? 32'h08 : 32'h00);
    chn_pkt_delay_err[0] = 1'b1;
    diag_clr             = 1'b1;
    repeat (4) tick();
    c = sticky_of(0);
    check("stk_set_wins", 32'(c[CAUSE_DLY]), 32'(STICKY_ON));
    diag_clr             = 1'b0;
    chn_pkt_delay_err[0] = 1'b0;
    repeat (3) tick();
    check("dly_cnt2", 32'(dut.g_chn[0].u_chn.dly_cnt_q), 32'd2);

    // Asynchronous reset in the middle of a packet burst.
    chn_pkt_eop[1] = 1'b1; chn_pkt_len_err[1] = 1'b1;
    repeat (3) tick();
    check("mid_len_cnt3", 32'(dut.g_chn[1].u_chn.len_cnt_q), 32'd3);
    rst_125m = 1'b0;
    #2;
    check("arst_err",     32'(slink_err),        32'hF);
    check("arst_cause",   32'(slink_err_cause),  32'h84210);
    check("arst_sticky",  32'(slink_err_sticky), 32'h0);
    check("arst_len1",    32'(dut.g_chn[1].u_chn.len_cnt_q), 32'd0);
    check("arst_len3",    32'(dut.g_chn[3].u_chn.len_cnt_q), 32'd0);
    check("arst_offline", 32'(dut.g_chn[1].u_chn.state_q),   32'(ST_OFFLINE));
    chn_pkt_eop = '0; chn_pkt_len_err = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
